dmem_responder: RTL and testbench

- Data-memory responder serving the load/store requests issued by the pipeline MEM stage.
- Accepts one word-sized request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Returns a single-cycle response pulse carrying read data, or an acknowledge for stores.
- Drives o_busy so the hazard unit can stall the pipeline while an access is in flight.

---
 rtl/dmem_responder_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 33 +++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, opcode/error
// codes and the word-index width helper used by the responder and its RAM.
package dmem_responder_pkg;

  // Common datapath width shared with the MEM stage.
  localparam int DMEM_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Opcode is {MemRead, MemWrite}; any other pattern is an opcode error.
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_OPCODE   = 2'b10;

  function automatic int word_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH x WIDTH, per-byte write enables.
// Read data is registered and reflects the contents before a same-edge write.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH = DMEM_WIDTH,
  parameter int DEPTH = 256
) (
  input  logic                          i_clk,
  input  logic                          i_en,
  input  logic [WIDTH/8-1:0]            i_we,
  input  logic [word_idx_w(DEPTH)-1:0]  i_idx,
  input  logic [WIDTH-1:0]              i_wdata,
  output logic [WIDTH-1:0]              o_rdata
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < NB; b++) begin
        if (i_we[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then pulses o_rsp_valid for one cycle with read data or an error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH   = DMEM_WIDTH,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_MemRead,
  input  logic               i_MemWrite,
  input  logic [WIDTH-1:0]   i_Address,
  input  logic [WIDTH-1:0]   i_WriteData,
  input  logic [WIDTH/8-1:0] i_ByteEn,
  output logic               o_rsp_valid,
  output logic [WIDTH-1:0]   o_ReadData,
  output logic               o_rsp_err,
  output logic               o_busy
);

  localparam int         IDX_W    = word_idx_w(DEPTH);
  localparam int         NB       = WIDTH / 8;
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [1:0]       r_op;
  logic [IDX_W+1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [NB-1:0]    r_be;
  logic [1:0]       r_err_code;
  logic             r_rsp_load;

  logic [1:0]       w_op;
  logic [IDX_W+1:0] w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic [NB-1:0]    w_be;
  logic [1:0]       w_err_code;
  logic             w_access;
  logic             w_ram_en;
  logic [NB-1:0]    w_ram_we;
  logic [WIDTH-1:0] w_ram_rdata;
  logic             w_unused_addr;

  // With zero latency the access edge is the accepting edge, so the request
  // fields come straight from the ports; otherwise from the latched copy.
  assign w_op    = (r_state == ST_IDLE) ? {i_MemRead, i_MemWrite} : r_op;
  assign w_addr  = (r_state == ST_IDLE) ? i_Address[IDX_W+1:0]    : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? i_WriteData              : r_wdata;
  assign w_be    = (r_state == ST_IDLE) ? i_ByteEn                 : r_be;

  assign w_err_code = ((w_addr[1:0] != 2'b00) ? ERR_MISALIGN : ERR_NONE)
                    | (((w_op != OP_LOAD) && (w_op != OP_STORE)) ? ERR_OPCODE : ERR_NONE);

  assign w_access = !i_rst &&
                    ((ZERO_LAT && (r_state == ST_IDLE) && i_req_valid) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd0)));
  assign w_ram_en = w_access && (w_err_code == ERR_NONE);
  assign w_ram_we = (w_op == OP_STORE) ? w_be : '0;

  // Upper address bits are deliberately ignored: addresses wrap.
  assign w_unused_addr = ^i_Address[WIDTH-1:IDX_W+2];

  dmem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_idx   (w_addr[IDX_W+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_op       <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_err_code <= ERR_NONE;
      r_rsp_load <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_op    <= {i_MemRead, i_MemWrite};
            r_addr  <= i_Address[IDX_W+1:0];
            r_wdata <= i_WriteData;
            r_be    <= i_ByteEn;
            r_cnt   <= CNT_INIT;
            r_state <= ZERO_LAT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      // Response attributes are captured at the access edge and held after.
      if (w_access) begin
        r_err_code <= w_err_code;
        r_rsp_load <= (w_op == OP_LOAD) && (w_err_code == ERR_NONE);
      end
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_err   = (r_err_code != ERR_NONE);
  assign o_ReadData  = r_rsp_load ? w_ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of request/response vectors plus
// hand-written sequences for busy/ignore behaviour and reset mid-access.
module tb_dmem_responder;

  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_req_valid = 1'b0;
  logic           o_req_ready;
  logic           i_MemRead = 1'b0;
  logic           i_MemWrite = 1'b0;
  logic [W-1:0]   i_Address = '0;
  logic [W-1:0]   i_WriteData = '0;
  logic [W/8-1:0] i_ByteEn = '0;
  logic           o_rsp_valid;
  logic [W-1:0]   o_ReadData;
  logic           o_rsp_err;
  logic           o_busy;

  int n_total = 0;
  int n_pass  = 0;

  dmem_responder #(
    .WIDTH   (W),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_MemRead   (i_MemRead),
    .i_MemWrite  (i_MemWrite),
    .i_Address   (i_Address),
    .i_WriteData (i_WriteData),
    .i_ByteEn    (i_ByteEn),
    .o_rsp_valid (o_rsp_valid),
    .o_ReadData  (o_ReadData),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string        name;
    logic         rd;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [3:0]   be;
    logic [W-1:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Presents one request in an idle cycle, scrambles the other inputs after
  // acceptance, and samples the response pulse at negedges.
  task automatic do_req(input logic rd, input logic wr, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input logic [3:0] be,
                        output logic [W-1:0] rdata, output logic err,
                        output int lat, output logic timeout);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_MemRead   = rd;
    i_MemWrite  = wr;
    i_Address   = addr;
    i_WriteData = wdata;
    i_ByteEn    = be;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_MemRead   = 1'($urandom_range(0, 1));
    i_MemWrite  = 1'($urandom_range(0, 1));
    i_Address   = $urandom;
    i_WriteData = $urandom;
    i_ByteEn    = 4'($urandom_range(0, 15));
    timeout = 1'b1;
    lat     = -1;
    rdata   = '0;
    err     = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (o_rsp_valid) begin
        lat     = k;
        rdata   = o_ReadData;
        err     = o_rsp_err;
        timeout = 1'b0;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  logic [W-1:0] rdata;
  logic         err;
  int           lat;
  logic         tmo;
  logic         saw_rsp;

  initial begin
    // Store/load round trips, byte lanes, errors, wrap and last-word cases.
    vecs[0]  = '{"pre_st20",   1'b0, 1'b1, 32'h20,  32'h0,        4'hF, 32'h0,        1'b0};
    vecs[1]  = '{"st_beef",    1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[2]  = '{"ld_beef",    1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{"st_lane0",   1'b0, 1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    vecs[4]  = '{"ld_lane0",   1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[5]  = '{"ld_misal",   1'b1, 1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[6]  = '{"rdwr_err",   1'b1, 1'b1, 32'h10,  32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{"ld_after_e", 1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vecs[8]  = '{"noop_err",   1'b0, 1'b0, 32'h10,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[9]  = '{"st_wrap",    1'b0, 1'b1, 32'h400, 32'h55,       4'hF, 32'h0,        1'b0};
    vecs[10] = '{"ld_wrap",    1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 32'h55,       1'b0};
    vecs[11] = '{"st_be0",     1'b0, 1'b1, 32'h0,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[12] = '{"ld_be0",     1'b1, 1'b0, 32'h0,   32'h0,        4'h0, 32'h55,       1'b0};
    vecs[13] = '{"st_last",    1'b0, 1'b1, 32'h3FC, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[14] = '{"st_lanesA",  1'b0, 1'b1, 32'h3FC, 32'hAABBCCDD, 4'hA, 32'h0,        1'b0};
    vecs[15] = '{"ld_last",    1'b1, 1'b0, 32'h3FC, 32'h0,        4'h0, 32'hAA22CC44, 1'b0};

    // Reset: two cycles high, then release.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready_in", {31'b0, o_req_ready}, 32'd1);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", {31'b0, o_req_ready}, 32'd1);
    chk("rst_busy",  {31'b0, o_busy},      32'd0);
    chk("rst_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("rst_err",   {31'b0, o_rsp_err},   32'd0);
    chk("rst_rdata", o_ReadData,           32'd0);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             rdata, err, lat, tmo);
      chk({vecs[i].name, "_tmo"},   {31'b0, tmo}, 32'd0);
      chk({vecs[i].name, "_rdata"}, rdata,        vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"},   {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"},   lat,          LAT);
    end

    // Busy/ignore: load 0x0, pulse a store to 0x0 during the first WAIT cycle.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0;
    i_Address = 32'h0; i_WriteData = 32'h0; i_ByteEn = 4'h0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("w1_busy",  {31'b0, o_busy},      32'd1);
    chk("w1_ready", {31'b0, o_req_ready}, 32'd0);
    i_req_valid = 1'b1; i_MemRead = 1'b0; i_MemWrite = 1'b1;
    i_Address = 32'h0; i_WriteData = 32'h99; i_ByteEn = 4'hF;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("w2_busy",  {31'b0, o_busy},      32'd1);
    chk("w2_valid", {31'b0, o_rsp_valid}, 32'd0);
    @(negedge i_clk);
    chk("rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
    chk("rsp_busy",  {31'b0, o_busy},      32'd1);
    chk("rsp_ready", {31'b0, o_req_ready}, 32'd0);
    chk("rsp_rdata", o_ReadData,           32'h55);
    @(negedge i_clk);
    chk("post_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("post_ready", {31'b0, o_req_ready}, 32'd1);
    chk("post_busy",  {31'b0, o_busy},      32'd0);
    chk("post_hold",  o_ReadData,           32'h55);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rdata, err, lat, tmo);
    chk("ign_tmo",   {31'b0, tmo}, 32'd0);
    chk("ign_rdata", rdata,        32'h55);

    // Reset in the first WAIT cycle of a store: the store must be dropped.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_MemRead = 1'b0; i_MemWrite = 1'b1;
    i_Address = 32'h20; i_WriteData = 32'h11111111; i_ByteEn = 4'hF;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("mr_ready", {31'b0, o_req_ready}, 32'd1);
    chk("mr_busy",  {31'b0, o_busy},      32'd0);
    chk("mr_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("mr_err",   {31'b0, o_rsp_err},   32'd0);
    chk("mr_rdata", o_ReadData,           32'd0);
    i_rst = 1'b0;
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_rsp_valid) saw_rsp = 1'b1;
    end
    chk("mr_no_rsp", {31'b0, saw_rsp}, 32'd0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rdata, err, lat, tmo);
    chk("mr_ld_tmo",   {31'b0, tmo}, 32'd0);
    chk("mr_ld_rdata", rdata,        32'h0);
    chk("mr_ld_err",   {31'b0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
